// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for pipe_hazard_ctrl: forwarding-select values and scoreboard entry fields.
// Forwarding is enabled by defining MINILA_FORWARD_EN.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    // Flag bits of one scoreboard entry, packed as {valid, wb_ena, is_load}.
    localparam int unsigned SB_FLAG_W = 3;

    // A source hits an entry only if it reads, the entry writes, and rd is not r0.
    function automatic logic rd_hit(input logic re, input logic valid, input logic wb_ena,
                                    input logic rd_eq, input logic rd_nonzero);
        return re & valid & wb_ena & rd_eq & rd_nonzero;
    endfunction

endpackage

// File: rtl/hz_sb_stage.sv
// One scoreboard entry of pipe_hazard_ctrl: registered {valid, rd, wb_ena, is_load} with bubble
// insert, plus RAW comparators against the two ID-stage sources.
module hz_sb_stage
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wb_ena,
    input  logic              in_is_load,
    input  logic [REG_AW-1:0] src_a,
    input  logic              re_a,
    input  logic [REG_AW-1:0] src_b,
    input  logic              re_b,
    output logic              valid,
    output logic [REG_AW-1:0] rd,
    output logic              wb_ena,
    output logic              is_load,
    output logic              hit_a,
    output logic              hit_b
);

    logic [SB_FLAG_W-1:0] flags;
    logic                 rd_nonzero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
            rd    <= '0;
        end else if (bubble) begin
            flags <= '0;
            rd    <= '0;
        end else begin
            flags <= {in_valid, in_wb_ena, in_is_load};
            rd    <= in_rd;
        end
    end

    assign {valid, wb_ena, is_load} = flags;
    assign rd_nonzero = |rd;

    assign hit_a = rd_hit(re_a, valid, wb_ena, rd == src_a, rd_nonzero);
    assign hit_b = rd_hit(re_b, valid, wb_ena, rd == src_b, rd_nonzero);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, interlock and bubble-tracking controller for the miniLA five-stage pipeline.
// Define MINILA_FORWARD_EN to enable operand forwarding (only load-use then stalls).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_re1,
    input  logic              id_re2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wb_ena,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              id_valid,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt,
    output logic [CNT_W-1:0]  perf_retire_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              redirect;
    logic              hazard;
    logic              stall;
    logic              ex_bubble;

    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
    logic              ex_wb_ena, mem_wb_ena, wb_wb_ena;
    logic              ex_is_load, mem_is_load, wb_is_load;
    logic              hit_a_ex, hit_b_ex, hit_a_mem, hit_b_mem, hit_a_wb, hit_b_wb;
    logic              unused_wb;

    assign redirect  = ex_redirect & ex_valid;
    assign stall     = hazard & ~redirect;
    assign ex_bubble = stall | redirect;

    assign pc_stall    = stall;
    assign if_id_stall = stall;
    assign if_id_flush = redirect;
    assign id_ex_flush = ex_bubble;

    hz_sb_stage #(.REG_AW(REG_AW)) u_ex (
        .clk        (cpu_clk),
        .rst        (cpu_rst),
        .bubble     (ex_bubble),
        .in_valid   (id_valid),
        .in_rd      (id_rd),
        .in_wb_ena  (id_wb_ena),
        .in_is_load (id_is_load),
        .src_a      (id_rs1),
        .re_a       (id_re1),
        .src_b      (id_rs2),
        .re_b       (id_re2),
        .valid      (ex_valid),
        .rd         (ex_rd),
        .wb_ena     (ex_wb_ena),
        .is_load    (ex_is_load),
        .hit_a      (hit_a_ex),
        .hit_b      (hit_b_ex)
    );

    hz_sb_stage #(.REG_AW(REG_AW)) u_mem (
        .clk        (cpu_clk),
        .rst        (cpu_rst),
        .bubble     (1'b0),
        .in_valid   (ex_valid),
        .in_rd      (ex_rd),
        .in_wb_ena  (ex_wb_ena),
        .in_is_load (ex_is_load),
        .src_a      (id_rs1),
        .re_a       (id_re1),
        .src_b      (id_rs2),
        .re_b       (id_re2),
        .valid      (mem_valid),
        .rd         (mem_rd),
        .wb_ena     (mem_wb_ena),
        .is_load    (mem_is_load),
        .hit_a      (hit_a_mem),
        .hit_b      (hit_b_mem)
    );

    hz_sb_stage #(.REG_AW(REG_AW)) u_wb (
        .clk        (cpu_clk),
        .rst        (cpu_rst),
        .bubble     (1'b0),
        .in_valid   (mem_valid),
        .in_rd      (mem_rd),
        .in_wb_ena  (mem_wb_ena),
        .in_is_load (mem_is_load),
        .src_a      (id_rs1),
        .re_a       (id_re1),
        .src_b      (id_rs2),
        .re_b       (id_re2),
        .valid      (wb_valid),
        .rd         (wb_rd),
        .wb_ena     (wb_wb_ena),
        .is_load    (wb_is_load),
        .hit_a      (hit_a_wb),
        .hit_b      (hit_b_wb)
    );

    // The WB entry is the end of the scoreboard; only its valid and comparators are consumed.
    assign unused_wb = ^{wb_rd, wb_wb_ena, wb_is_load};

`ifdef MINILA_FORWARD_EN
    fwd_sel_e sel_a, sel_b;

    // Youngest producer wins; a load still in EX cannot forward and stalls instead.
    always_comb begin
        sel_a = FWD_RF;
        if (hit_a_ex)       sel_a = ex_is_load ? FWD_RF : FWD_EX;
        else if (hit_a_mem) sel_a = FWD_MEM;
        else if (hit_a_wb)  sel_a = FWD_WB;
    end

    always_comb begin
        sel_b = FWD_RF;
        if (hit_b_ex)       sel_b = ex_is_load ? FWD_RF : FWD_EX;
        else if (hit_b_mem) sel_b = FWD_MEM;
        else if (hit_b_wb)  sel_b = FWD_WB;
    end

    assign hazard    = (hit_a_ex | hit_b_ex) & ex_is_load;
    assign fwd_sel_a = sel_a;
    assign fwd_sel_b = sel_b;
`else
    assign hazard    = hit_a_ex | hit_b_ex | hit_a_mem | hit_b_mem | hit_a_wb | hit_b_wb;
    assign fwd_sel_a = FWD_RF;
    assign fwd_sel_b = FWD_RF;
`endif

    // A stalled ID instruction stays put; a redirect kills it.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            id_valid <= 1'b0;
        end else if (redirect) begin
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_valid <= 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            perf_stall_cnt  <= '0;
            perf_flush_cnt  <= '0;
            perf_retire_cnt <= '0;
        end else begin
            if (stall && perf_stall_cnt != CNT_MAX) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_ONE;
            end
            if (redirect && perf_flush_cnt != CNT_MAX) begin
                perf_flush_cnt <= perf_flush_cnt + CNT_ONE;
            end
            if (wb_valid && perf_retire_cnt != CNT_MAX) begin
                perf_retire_cnt <= perf_retire_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle vector table plus reset/saturation sequences.
// Expectations follow MINILA_FORWARD_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 3;
    localparam int          CNT_SAT = (1 << CNT_W) - 1;

`ifdef MINILA_FORWARD_EN
    localparam int EXP_STALLS  = 1;
    localparam int EXP_FLUSHES = 1;
`else
    localparam int EXP_STALLS  = 3;
    localparam int EXP_FLUSHES = 2;
`endif

    logic              cpu_clk = 1'b0;
    logic              cpu_rst;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_re1, id_re2, id_wb_ena, id_is_load, ex_redirect;
    logic              pc_stall, if_id_stall, if_id_flush, id_ex_flush;
    logic [1:0]        fwd_sel_a, fwd_sel_b;
    logic              id_valid, ex_valid, mem_valid, wb_valid;
    logic [CNT_W-1:0]  perf_stall_cnt, perf_flush_cnt, perf_retire_cnt;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .cpu_clk         (cpu_clk),
        .cpu_rst         (cpu_rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_re1          (id_re1),
        .id_re2          (id_re2),
        .id_rd           (id_rd),
        .id_wb_ena       (id_wb_ena),
        .id_is_load      (id_is_load),
        .ex_redirect     (ex_redirect),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .fwd_sel_a       (fwd_sel_a),
        .fwd_sel_b       (fwd_sel_b),
        .id_valid        (id_valid),
        .ex_valid        (ex_valid),
        .mem_valid       (mem_valid),
        .wb_valid        (wb_valid),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt),
        .perf_retire_cnt (perf_retire_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       re1, re2;
        logic [4:0] rd;
        logic       wb, ld, redir;
        logic       stall, iflush, eflush;
        logic       chk_sel;
        logic [1:0] sel_a, sel_b;
        logic [3:0] valids;  // {id, ex, mem, wb}
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic re1,
                                input logic re2, input logic [4:0] rd, input logic wb,
                                input logic ld, input logic redir, input logic stall,
                                input logic iflush, input logic eflush, input logic chk_sel,
                                input logic [1:0] sel_a, input logic [1:0] sel_b,
                                input logic [3:0] valids);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.re1 = re1; v.re2 = re2; v.rd = rd;
        v.wb = wb; v.ld = ld; v.redir = redir;
        v.stall = stall; v.iflush = iflush; v.eflush = eflush;
        v.chk_sel = chk_sel; v.sel_a = sel_a; v.sel_b = sel_b; v.valids = valids;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_re1 = v.re1; id_re2 = v.re2;
        id_rd = v.rd; id_wb_ena = v.wb; id_is_load = v.ld; ex_redirect = v.redir;
    endtask

    task automatic drive_nop();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    endtask

    task automatic check_row(input int i);
        vec_t e;
        if (exp_q.size() == 0) begin
            chk($sformatf("row%0d scoreboard empty", i), 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk($sformatf("row%0d pc_stall", i), pc_stall, e.stall);
        chk($sformatf("row%0d if_id_stall", i), if_id_stall, e.stall);
        chk($sformatf("row%0d if_id_flush", i), if_id_flush, e.iflush);
        chk($sformatf("row%0d id_ex_flush", i), id_ex_flush, e.eflush);
        chk($sformatf("row%0d valids", i), {id_valid, ex_valid, mem_valid, wb_valid}, e.valids);
        if (e.chk_sel) begin
            chk($sformatf("row%0d fwd_sel_a", i), fwd_sel_a, e.sel_a);
            chk($sformatf("row%0d fwd_sel_b", i), fwd_sel_b, e.sel_b);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_retire;
        int found;

`ifdef MINILA_FORWARD_EN
        // rs1 rs2 re1 re2 rd wb ld rdr | stall ifl efl chk sa sb valids
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 1, 0, 0, 4'b1000));
        tbl.push_back(mk(5, 0, 1, 0, 6, 1, 1, 0,  0, 0, 0, 1, 1, 0, 4'b1100));
        tbl.push_back(mk(6, 5, 1, 1, 7, 1, 0, 0,  1, 0, 1, 0, 0, 0, 4'b1110));
        tbl.push_back(mk(6, 5, 1, 1, 7, 1, 0, 0,  0, 0, 0, 1, 2, 3, 4'b1011));
        tbl.push_back(mk(7, 0, 1, 1, 0, 1, 0, 0,  0, 0, 0, 1, 1, 0, 4'b1101));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 4'b1110));
        tbl.push_back(mk(0, 0, 0, 0, 9, 1, 1, 0,  0, 0, 0, 1, 0, 0, 4'b1111));
        tbl.push_back(mk(9, 0, 1, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 4'b1111));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 4'b0011));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 4'b1001));
`else
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 7, 1, 0, 0,  0, 0, 0, 1, 0, 0, 4'b1000));
        tbl.push_back(mk(7, 0, 1, 0, 8, 1, 0, 0,  1, 0, 1, 1, 0, 0, 4'b1100));
        tbl.push_back(mk(7, 0, 1, 0, 8, 1, 0, 0,  1, 0, 1, 1, 0, 0, 4'b1010));
        tbl.push_back(mk(7, 0, 1, 0, 8, 1, 0, 0,  1, 0, 1, 1, 0, 0, 4'b1001));
        tbl.push_back(mk(7, 0, 1, 0, 8, 1, 0, 0,  0, 0, 0, 1, 0, 0, 4'b1000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 4'b1100));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 4'b1110));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 4'b1111));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 1, 0, 0, 4'b1111));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 4'b0011));
        tbl.push_back(mk(0, 0, 0, 0, 9, 1, 0, 0,  0, 0, 0, 1, 0, 0, 4'b1001));
        tbl.push_back(mk(9, 0, 1, 0, 0, 0, 0, 1,  0, 1, 1, 1, 0, 0, 4'b1100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 4'b0010));
`endif

        cpu_rst = 1'b1;
        drive_nop();
        repeat (2) @(negedge cpu_clk);
        chk("reset valids", {id_valid, ex_valid, mem_valid, wb_valid}, 0);
        chk("reset counters", {perf_stall_cnt, perf_flush_cnt, perf_retire_cnt}, 0);
        chk("reset controls", {pc_stall, if_id_stall, if_id_flush, id_ex_flush}, 0);
        chk("reset fwd_sel", {fwd_sel_a, fwd_sel_b}, 0);

        cpu_rst = 1'b0;
        exp_retire = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            if (tbl[i].valids[0]) exp_retire++;
            #2;
            check_row(i);
            @(negedge cpu_clk);
        end
        drive_nop();
        if (exp_retire > CNT_SAT) exp_retire = CNT_SAT;
        chk("perf_stall_cnt", perf_stall_cnt, EXP_STALLS);
        chk("perf_flush_cnt", perf_flush_cnt, EXP_FLUSHES);
        chk("perf_retire_cnt", perf_retire_cnt, exp_retire);

        // Load into r3 then a reader: stalls in either configuration, then reset mid-stall.
        drive(mk(0, 0, 0, 0, 3, 1, 1, 0,  0, 0, 0, 0, 0, 0, 4'b0000));
        @(negedge cpu_clk);
        drive(mk(3, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4'b0000));
        #2;
        chk("load-use stall before reset", pc_stall, 1);
        cpu_rst = 1'b1;
        #1;
        chk("mid-stall reset valids", {id_valid, ex_valid, mem_valid, wb_valid}, 0);
        chk("mid-stall reset counters", {perf_stall_cnt, perf_flush_cnt, perf_retire_cnt}, 0);
        chk("mid-stall reset pc_stall", pc_stall, 0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        drive_nop();

        found = -1;
        for (int k = 0; k < 10; k++) begin
            #2;
            if (wb_valid) begin
                found = k;
                break;
            end
            @(negedge cpu_clk);
        end
        chk("wb_valid rise after release", found, 4);
        chk("retire at wb rise", perf_retire_cnt, 0);
        repeat (3) @(posedge cpu_clk);
        #1;
        chk("retire after 3 cycles", perf_retire_cnt, 3);
        repeat (10) @(posedge cpu_clk);
        #1;
        chk("retire saturates", perf_retire_cnt, CNT_SAT);
        chk("stall cnt after reset", perf_stall_cnt, 0);
        chk("flush cnt after reset", perf_flush_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
